// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: holds all downstream stage resets after a trigger
// (board reset or accepted soft request), then releases them one by one in
// bit order with a fixed gap, and finally flags sys_ready. Soft requests use
// a four-phase req/ack handshake that completes only at the end of a
// soft-triggered sequence.
module reset_release_sequencer #(
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_req,
  output logic              soft_ack,
  output logic [STAGES-1:0] rst_out,
  output logic              sys_ready,
  output logic [1:0]        state_dbg
);

  // idx must be able to hold STAGES itself: that value marks the final gap
  // wait between the last release and sys_ready.
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES + 1) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_DONE  = IDX_W'(STAGES);
  localparam logic [STAGES-1:0] ONE       = STAGES'(1);

  typedef enum logic [1:0] {
    S_HOLD = 2'b01,
    S_REL  = 2'b10,
    S_RUN  = 2'b11
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             soft_pend;  // current sequence was started by soft_req

  assign state_dbg = state;

  // Sequencer FSM: all outputs registered; reset outranks any soft request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_out   <= '1;
      sys_ready <= 1'b0;
      soft_ack  <= 1'b0;
      soft_pend <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            // Stage 0 leaves reset; with one stage the REL state only
            // performs the final gap wait since idx already equals STAGES.
            rst_out <= rst_out & ~ONE;
            cnt     <= '0;
            idx     <= IDX_W'(1);
            state   <= S_REL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_REL: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx == IDX_DONE) begin
              state     <= S_RUN;
              sys_ready <= 1'b1;
              soft_ack  <= soft_pend;
              soft_pend <= 1'b0;
            end else begin
              rst_out <= rst_out & ~(ONE << idx);
              idx     <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (soft_ack) begin
            // Handshake return-to-zero; a held request is not a new one.
            if (!soft_req) soft_ack <= 1'b0;
          end else if (soft_req) begin
            state     <= S_HOLD;
            cnt       <= '0;
            idx       <= '0;
            rst_out   <= '1;
            sys_ready <= 1'b0;
            soft_pend <= 1'b1;
          end
        end
        default: begin
          state     <= S_HOLD;
          cnt       <= '0;
          idx       <= '0;
          rst_out   <= '1;
          sys_ready <= 1'b0;
          soft_ack  <= 1'b0;
          soft_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: a default-parameter instance and a
// minimal (1 stage, 1 hold, 1 gap) instance share the same stimulus. The
// reference model tracks only cycles elapsed since the last trigger and
// derives every output from the release schedule arithmetic.
module tb_reset_release_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, soft_req;
  logic       a_ack, a_rdy, b_ack, b_rdy;
  logic [2:0] a_rst;
  logic [0:0] b_rst;
  logic [1:0] a_dbg, b_dbg;

  int checks = 0;
  int errors = 0;

  reset_release_sequencer u_dut (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(a_ack),
    .rst_out(a_rst), .sys_ready(a_rdy), .state_dbg(a_dbg)
  );

  reset_release_sequencer #(
    .STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_W(4)
  ) u_small (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(b_ack),
    .rst_out(b_rst), .sys_ready(b_rdy), .state_dbg(b_dbg)
  );

  // Reference model state per instance
  int hp[2] = '{16, 1};
  int gp[2] = '{8, 1};
  int sp[2] = '{3, 1};
  int t[2];
  bit pend[2];
  bit ack[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int done;
      done = hp[k] + sp[k] * gp[k];
      if (reset) begin
        t[k] = 0; pend[k] = 0; ack[k] = 0;
      end else if (t[k] >= done) begin
        if (ack[k]) begin
          if (!soft_req) ack[k] = 0;
        end else if (soft_req) begin
          t[k] = 0; pend[k] = 1;
        end
      end else begin
        t[k]++;
        if (t[k] == done) begin
          ack[k] = pend[k];
          pend[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_rst(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < sp[k]; i++) v[i] = (t[k] < hp[k] + i * gp[k]);
    return v;
  endfunction

  function automatic logic [31:0] exp_dbg(input int k);
    if (t[k] < hp[k]) return 32'd1;
    if (t[k] < hp[k] + sp[k] * gp[k]) return 32'd2;
    return 32'd3;
  endfunction

  function automatic logic [31:0] exp_rdy(input int k);
    return (t[k] >= hp[k] + sp[k] * gp[k]) ? 32'd1 : 32'd0;
  endfunction

  task automatic compare();
    chk("a_rst", 32'(a_rst), exp_rst(0));
    chk("a_rdy", 32'(a_rdy), exp_rdy(0));
    chk("a_ack", 32'(a_ack), 32'(ack[0]));
    chk("a_dbg", 32'(a_dbg), exp_dbg(0));
    chk("b_rst", 32'(b_rst), exp_rst(1));
    chk("b_rdy", 32'(b_rdy), exp_rdy(1));
    chk("b_ack", 32'(b_ack), 32'(ack[1]));
    chk("b_dbg", 32'(b_dbg), exp_dbg(1));
  endtask

  // One cycle: drive inputs, let the edge happen, check on the falling edge.
  task automatic cyc(input logic r, input logic s);
    reset    = r;
    soft_req = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic s;
    reset = 1'b1;
    soft_req = 1'b0;
    t = '{0, 0};
    pend = '{0, 0};
    ack = '{0, 0};

    // Power-on reset then full release schedule
    repeat (5) cyc(1'b1, 1'b0);
    repeat (45) cyc(1'b0, 1'b0);
    // Held soft request: full sequence, ack, no retrigger while acked
    repeat (60) cyc(1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0);
    // Reset pulse mid-release (after stage 1 clears)
    cyc(1'b1, 1'b0);
    repeat (27) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (45) cyc(1'b0, 1'b0);
    // Reset and soft request on the same edge in RUN
    cyc(1'b1, 1'b1);
    repeat (50) cyc(1'b0, 1'b0);
    // One-cycle soft pulse in RUN
    cyc(1'b0, 1'b1);
    repeat (50) cyc(1'b0, 1'b0);
    // Soft request dropped mid-sequence, then reasserted late
    cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    repeat (40) cyc(1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0);
    // Randomized traffic
    s = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) s = ~s;
      cyc(($urandom_range(0, 199) == 0), s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
